// File: rtl/scalar_alu_arbiter_if.sv
// Requester-side bus of the scalar ALU arbiter.
//   master : the requester cluster (drives requests, consumes responses)
//   slave  : the arbiter (grants requests, presents the response slot)
// Per-requester fields are packed, with requester i in slice [i*W +: W].
interface scalar_alu_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 32,
    parameter int OP_W   = 4,
    parameter int ID_W   = $clog2(NREQ)
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*OP_W-1:0]   req_op;
    logic [NREQ*WORD_W-1:0] req_porta;
    logic [NREQ*WORD_W-1:0] req_portb;

    logic [NREQ-1:0]        rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [WORD_W-1:0]      rsp_out;
    logic                   rsp_zf;
    logic                   rsp_nf;
    logic                   rsp_of;
    logic [NREQ-1:0]        rsp_ready;

    modport master (
        output req_valid, req_op, req_porta, req_portb, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_zf, rsp_nf, rsp_of
    );

    modport slave (
        input  req_valid, req_op, req_porta, req_portb, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out, rsp_zf, rsp_nf, rsp_of
    );
endinterface

// File: rtl/scalar_alu_arbiter.sv
// Shares one scalar ALU among NREQ requesters. One request per cycle is
// granted round-robin, its op/operands are steered to the ALU, and the ALU
// result plus flags are captured into a one-entry response slot that is
// held until the owning requester consumes it. Two saturating counters
// track consumed responses and consumed responses with overflow.
//
// Ports:
//   CLK, nRST              clock, asynchronous active-low reset
//   bus (slave)            requester handshake and response slot
//   alu_op/porta/portb     operands of the granted request to the ALU
//   alu_out/zf/nf/of       combinational ALU result and flags
//   op_count, of_count     saturating statistics
//
// Slot FSM:
//   state   | meaning
//   S_EMPTY | no response held; any valid request can be granted
//   S_FULL  | response held for rsp_id; new grant only when it is consumed
module scalar_alu_arbiter #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 32,
    parameter int OP_W   = 4,
    parameter int ID_W   = $clog2(NREQ),
    parameter int CNT_W  = 16
) (
    input  logic                  CLK,
    input  logic                  nRST,
    scalar_alu_arbiter_if.slave   bus,
    output logic [OP_W-1:0]       alu_op,
    output logic [WORD_W-1:0]     alu_porta,
    output logic [WORD_W-1:0]     alu_portb,
    input  logic [WORD_W-1:0]     alu_out,
    input  logic                  alu_zf,
    input  logic                  alu_nf,
    input  logic                  alu_of,
    output logic [CNT_W-1:0]      op_count,
    output logic [CNT_W-1:0]      of_count
);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rsp_id_q;
    logic [WORD_W-1:0] rsp_out_q;
    logic              rsp_zf_q, rsp_nf_q, rsp_of_q;
    logic [CNT_W-1:0]  op_count_q, of_count_q;

    logic [ID_W-1:0]   win;
    logic              any_valid;
    logic              full;
    logic              consume;
    logic              free;
    logic              accept;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   rsp_vld;
    logic [ID_W-1:0]   next_ptr;

    assign full    = (state_q == S_FULL);
    assign consume = full && bus.rsp_ready[rsp_id_q];
    assign free    = !full || consume;

    // Scan from the highest offset down so the lowest offset from rr_ptr
    // (the highest-priority requester) is the last to overwrite win.
    always_comb begin
        int idx;
        win       = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (bus.req_valid[idx]) begin
                win       = ID_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

    // Grant is gated by reset so nothing can be handed out while nRST is low.
    always_comb begin
        grant = '0;
        if (free && any_valid && nRST)
            grant[win] = 1'b1;
    end

    assign accept = free && any_valid;

    // ALU steering ignores slot occupancy; only the grant depends on it.
    always_comb begin
        alu_op    = '0;
        alu_porta = '0;
        alu_portb = '0;
        if (any_valid) begin
            alu_op    = bus.req_op[int'(win)*OP_W +: OP_W];
            alu_porta = bus.req_porta[int'(win)*WORD_W +: WORD_W];
            alu_portb = bus.req_portb[int'(win)*WORD_W +: WORD_W];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (accept) state_d = S_FULL;
            S_FULL:  if (consume && !accept) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        rsp_vld = '0;
        if (full)
            rsp_vld[rsp_id_q] = 1'b1;
    end

    assign next_ptr = (int'(win) == NREQ - 1) ? '0 : win + ID_W'(1);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state_q <= S_EMPTY;
        else
            state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr    <= '0;
            rsp_id_q  <= '0;
            rsp_out_q <= '0;
            rsp_zf_q  <= 1'b0;
            rsp_nf_q  <= 1'b0;
            rsp_of_q  <= 1'b0;
        end else if (accept) begin
            rr_ptr    <= next_ptr;
            rsp_id_q  <= win;
            rsp_out_q <= alu_out;
            rsp_zf_q  <= alu_zf;
            rsp_nf_q  <= alu_nf;
            rsp_of_q  <= alu_of;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op_count_q <= '0;
            of_count_q <= '0;
        end else if (consume) begin
            if (op_count_q != '1)
                op_count_q <= op_count_q + CNT_W'(1);
            if (rsp_of_q && (of_count_q != '1))
                of_count_q <= of_count_q + CNT_W'(1);
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_vld;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_out   = rsp_out_q;
    assign bus.rsp_zf    = rsp_zf_q;
    assign bus.rsp_nf    = rsp_nf_q;
    assign bus.rsp_of    = rsp_of_q;
    assign op_count      = op_count_q;
    assign of_count      = of_count_q;

endmodule

// File: tb/tb_scalar_alu_arbiter.sv
// Directed testbench for scalar_alu_arbiter with a small behavioural ALU.
module tb_scalar_alu_arbiter;
    localparam int NREQ   = 4;
    localparam int WORD_W = 32;
    localparam int OP_W   = 4;
    localparam int ID_W   = 2;
    localparam int CNT_W  = 16;

    localparam logic [OP_W-1:0] ALU_ADD = 4'd1;
    localparam logic [OP_W-1:0] ALU_SUB = 4'd2;
    localparam logic [OP_W-1:0] ALU_BAD = 4'hF;

    logic              CLK;
    logic              nRST;
    logic [OP_W-1:0]   alu_op;
    logic [WORD_W-1:0] alu_porta, alu_portb, alu_out;
    logic              alu_zf, alu_nf, alu_of;
    logic [CNT_W-1:0]  op_count, of_count;

    int vectors;
    int miscompares;

    scalar_alu_arbiter_if #(.NREQ(NREQ), .WORD_W(WORD_W), .OP_W(OP_W), .ID_W(ID_W)) bus ();

    scalar_alu_arbiter #(
        .NREQ(NREQ), .WORD_W(WORD_W), .OP_W(OP_W), .ID_W(ID_W), .CNT_W(CNT_W)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .bus      (bus.slave),
        .alu_op   (alu_op),
        .alu_porta(alu_porta),
        .alu_portb(alu_portb),
        .alu_out  (alu_out),
        .alu_zf   (alu_zf),
        .alu_nf   (alu_nf),
        .alu_of   (alu_of),
        .op_count (op_count),
        .of_count (of_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural ALU: add/sub with signed overflow, zero for unknown ops.
    always_comb begin
        alu_out = '0;
        alu_of  = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_out = alu_porta + alu_portb;
                alu_of  = (alu_porta[31] == alu_portb[31]) && (alu_out[31] != alu_porta[31]);
            end
            ALU_SUB: begin
                alu_out = alu_porta - alu_portb;
                alu_of  = (alu_porta[31] != alu_portb[31]) && (alu_out[31] != alu_porta[31]);
            end
            default: alu_out = '0;
        endcase
        alu_zf = (alu_out == '0);
        alu_nf = alu_out[31];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [OP_W-1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        bus.req_op[i*OP_W +: OP_W]      = op;
        bus.req_porta[i*WORD_W +: WORD_W] = a;
        bus.req_portb[i*WORD_W +: WORD_W] = b;
    endtask

    // Sample point just after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] oh(input int i);
        logic [31:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        int g;
        vectors     = 0;
        miscompares = 0;
        nRST          = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_op    = '0;
        bus.req_porta = '0;
        bus.req_portb = '0;
        bus.rsp_ready = '0;
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
        check("rst_rsp_out",   bus.rsp_out,        32'h0);
        check("rst_flags",     {29'b0, bus.rsp_zf, bus.rsp_nf, bus.rsp_of}, 32'h0);
        check("rst_op_count",  32'(op_count),      32'h0);
        check("rst_of_count",  32'(of_count),      32'h0);

        @(negedge CLK);
        bus.req_valid = '0;
        @(negedge CLK);
        nRST = 1'b1;

        // Single request from requester 2: ADD 5,7.
        @(negedge CLK);
        set_req(2, ALU_ADD, 32'd5, 32'd7);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 4'hF;
        #1;
        check("single_grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        check("single_rsp_valid", 32'(bus.rsp_valid), 32'h4);
        check("single_rsp_id",    32'(bus.rsp_id),    32'd2);
        check("single_rsp_out",   bus.rsp_out,        32'd12);
        check("single_flags",     {29'b0, bus.rsp_zf, bus.rsp_nf, bus.rsp_of}, 32'h0);
        check("single_cnt_before", 32'(op_count),     32'd0);
        tick();
        check("single_cnt_after", 32'(op_count),      32'd1);
        check("single_drained",   32'(bus.rsp_valid), 32'h0);

        // All four valid; pointer sits at 3 after the previous grant to 2.
        @(negedge CLK);
        for (int i = 0; i < NREQ; i++) set_req(i, ALU_ADD, 32'(i * 10), 32'd1);
        bus.req_valid = 4'hF;
        g = 3;
        for (int n = 0; n < 5; n++) begin
            #1;
            check("rr_grant", 32'(bus.req_ready), oh(g));
            tick();
            check("rr_rsp_valid", 32'(bus.rsp_valid), oh(g));
            check("rr_rsp_out",   bus.rsp_out,        32'(g * 10 + 1));
            g = (g + 1) % NREQ;
            @(negedge CLK);
        end
        bus.req_valid = '0;
        tick();
        check("rr_op_count", 32'(op_count), 32'd6);

        // Backpressure: requester 1 holds its result for 3 cycles.
        @(negedge CLK);
        set_req(1, ALU_ADD, 32'd100, 32'd23);
        set_req(3, ALU_SUB, 32'd50, 32'd8);
        bus.req_valid = 4'b0010;
        bus.rsp_ready = 4'b1101;
        #1;
        check("bp_grant1", 32'(bus.req_ready), 32'h2);
        for (int n = 0; n < 3; n++) begin
            @(negedge CLK);
            bus.req_valid = 4'b1000;
            #1;
            check("bp_hold_ready", 32'(bus.req_ready), 32'h0);
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'h2);
            check("bp_hold_out",   bus.rsp_out,        32'd123);
            check("bp_hold_flags", {29'b0, bus.rsp_zf, bus.rsp_nf, bus.rsp_of}, 32'h0);
        end
        bus.rsp_ready = 4'hF;
        #1;
        check("bp_release_grant", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = '0;
        check("bp_next_id",  32'(bus.rsp_id), 32'd3);
        check("bp_next_out", bus.rsp_out,     32'd42);
        tick();
        check("bp_op_count", 32'(op_count), 32'd8);

        // Overflow, zero result, unknown opcode back-to-back.
        @(negedge CLK);
        set_req(0, ALU_ADD, 32'h7FFF_FFFF, 32'd1);
        bus.req_valid = 4'b0001;
        #1;
        check("ovf_grant", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = '0;
        check("ovf_out",   bus.rsp_out, 32'h8000_0000);
        check("ovf_flags", {29'b0, bus.rsp_zf, bus.rsp_nf, bus.rsp_of}, 32'h3);
        tick();
        check("ovf_of_count", 32'(of_count), 32'd1);
        check("ovf_op_count", 32'(op_count), 32'd9);
        @(negedge CLK);
        set_req(1, ALU_SUB, 32'd3, 32'd3);
        bus.req_valid = 4'b0010;
        tick();
        check("sub_zero_out",   bus.rsp_out, 32'h0);
        check("sub_zero_flags", {29'b0, bus.rsp_zf, bus.rsp_nf, bus.rsp_of}, 32'h4);
        @(negedge CLK);
        set_req(2, ALU_BAD, 32'd9, 32'd9);
        bus.req_valid = 4'b0100;
        #1;
        check("b2b_grant", 32'(bus.req_ready), 32'h4);
        tick();
        bus.req_valid = '0;
        check("bad_op_id",    32'(bus.rsp_id), 32'd2);
        check("bad_op_out",   bus.rsp_out,     32'h0);
        check("bad_op_flags", {29'b0, bus.rsp_zf, bus.rsp_nf, bus.rsp_of}, 32'h4);
        tick();
        check("bad_op_counts", {op_count, of_count}, {16'd11, 16'd1});

        // Asynchronous reset while the slot is full for requester 2.
        @(negedge CLK);
        set_req(2, ALU_ADD, 32'd1, 32'd1);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = '0;
        tick();
        bus.req_valid = '0;
        check("mid_full", 32'(bus.rsp_valid), 32'h4);
        #2;
        nRST = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
        check("mid_rst_out",   bus.rsp_out,        32'h0);
        check("mid_rst_counts", {op_count, of_count}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        set_req(0, ALU_ADD, 32'd2, 32'd3);
        set_req(3, ALU_ADD, 32'd4, 32'd5);
        bus.req_valid = 4'b1001;
        bus.rsp_ready = 4'hF;
        #1;
        check("post_rst_no_rsp", 32'(bus.rsp_valid), 32'h0);
        check("post_rst_grant0", 32'(bus.req_ready), 32'h1);
        tick();
        check("post_rst_id", 32'(bus.rsp_id), 32'd0);
        check("post_rst_out", bus.rsp_out,    32'd5);
        @(negedge CLK);
        #1;
        check("post_rst_grant3", 32'(bus.req_ready), 32'h8);
        tick();
        bus.req_valid = '0;
        check("post_rst_id3", 32'(bus.rsp_id), 32'd3);
        tick();
        check("post_rst_op_count", 32'(op_count), 32'd2);

        // Saturation of op_count.
        @(negedge CLK);
        force dut.op_count_q = 16'hFFFF;
        #1;
        release dut.op_count_q;
        set_req(0, ALU_ADD, 32'd1, 32'd2);
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = '0;
        tick();
        check("sat_consumed", 32'(bus.rsp_valid), 32'h0);
        check("sat_op_count", 32'(op_count), 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
